// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder sequencer: drives one shared single-digit BCD adder
// per clock, least-significant digit first, and latches the multi-digit sum and carry.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    input  logic                  cin,
    output logic [3:0]            add_a,
    output logic [3:0]            add_b,
    output logic                  add_cin,
    input  logic [3:0]            add_s,
    input  logic                  add_c,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum_bcd,
    output logic                  cout,
    output logic                  err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_reg;
    logic [DIGITS-1:0][3:0]    a_reg;
    logic [DIGITS-1:0][3:0]    b_reg;
    logic [DIGITS-1:0][3:0]    sum_reg;
    logic [IDX_W-1:0]          idx_reg;
    logic                      carry_reg;
    logic                      cout_reg;
    logic                      err_reg;
    logic                      busy_reg;
    logic                      done_reg;
    logic [DIGITS-1:0]         digit_bad;
    logic                      run;

    // Any non-decimal nibble in either operand flags the whole operation.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_chk
        assign digit_bad[gi] = (a_bcd[4*gi +: 4] > 4'd9) || (b_bcd[4*gi +: 4] > 4'd9);
    end

    assign run     = (state_reg == RUN);
    assign add_a   = run ? a_reg[idx_reg] : 4'd0;
    assign add_b   = run ? b_reg[idx_reg] : 4'd0;
    assign add_cin = run ? carry_reg : 1'b0;

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign sum_bcd = sum_reg;
    assign cout    = cout_reg;
    assign err     = err_reg;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a_bcd;
                        b_reg     <= b_bcd;
                        carry_reg <= cin;
                        idx_reg   <= '0;
                        sum_reg   <= '0;
                        cout_reg  <= 1'b0;
                        err_reg   <= |digit_bad;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // The shared adder is combinational, so its result is captured this edge.
                    sum_reg[idx_reg] <= add_s;
                    carry_reg        <= add_c;
                    if (idx_reg == LAST_IDX) begin
                        cout_reg  <= add_c;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl: models the shared digit adder, queues
// expected results at accept time and checks them when done pulses.
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;

    logic        Clock;
    logic        Resetn;
    logic        start;
    logic [15:0] a_bcd;
    logic [15:0] b_bcd;
    logic        cin;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_s;
    logic        add_c;
    logic        busy;
    logic        done;
    logic [15:0] sum_bcd;
    logic        cout;
    logic        err;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        err;
        int          done_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   cyc      = 0;
    logic prev_done = 1'b0;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .start   (start),
        .a_bcd   (a_bcd),
        .b_bcd   (b_bcd),
        .cin     (cin),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_cin (add_cin),
        .add_s   (add_s),
        .add_c   (add_c),
        .busy    (busy),
        .done    (done),
        .sum_bcd (sum_bcd),
        .cout    (cout),
        .err     (err)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) cyc <= cyc + 1;

    // External single-digit BCD adder model.
    always_comb begin
        logic [4:0] f;
        f = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
        if (f > 5'd9) begin
            add_s = 4'(f - 5'd10);
            add_c = 1'b1;
        end else begin
            add_s = f[3:0];
            add_c = 1'b0;
        end
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge Clock) begin
        exp_t e;
        if (prev_done) check("done_width", done, 0);
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("sum_bcd", sum_bcd, e.sum);
                check("cout", cout, e.cout);
                check("err", err, e.err);
                check("done_cycle", cyc, e.done_cyc);
                $display("done: sum=%h cout=%0d err=%0d cyc=%0d", sum_bcd, cout, err, cyc);
            end
        end
        prev_done = done;
    end

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                            input logic [15:0] ex_sum, input logic ex_cout, input logic ex_err,
                            input bit expect_done);
        exp_t e;
        @(negedge Clock);
        a_bcd = a;
        b_bcd = b;
        cin   = c;
        start = 1'b1;
        @(posedge Clock);
        #1;
        start = 1'b0;
        a_bcd = 16'hFFFF;
        b_bcd = 16'hEEEE;
        cin   = 1'b1;
        $display("start: a=%h b=%h cin=%0d at cyc=%0d", a, b, c, cyc);
        check("busy_after_accept", busy, 1);
        check("sum_cleared", sum_bcd, 0);
        check("err_at_accept", err, ex_err);
        if (expect_done) begin
            e.sum      = ex_sum;
            e.cout     = ex_cout;
            e.err      = ex_err;
            e.done_cyc = cyc + DIGITS;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    initial begin
        Resetn = 1'b0;
        start  = 1'b0;
        a_bcd  = '0;
        b_bcd  = '0;
        cin    = 1'b0;
        @(negedge Clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum_bcd, 0);
        check("rst_add_a", add_a, 0);
        @(negedge Clock);
        Resetn = 1'b1;

        start_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1);
        wait_idle();
        start_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        wait_idle();
        start_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1);
        wait_idle();

        // Mid-run start with different operands must be ignored.
        start_op(16'h4567, 16'h2345, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1);
        @(negedge Clock);
        a_bcd = 16'h1111;
        b_bcd = 16'h1111;
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        wait_idle();

        // Reset while idx=2: outputs clear at once, no done.
        start_op(16'h1234, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge Clock);
        #1;
        @(posedge Clock);
        #1;
        Resetn = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_sum", sum_bcd, 0);
        check("abort_add_a", add_a, 0);
        check("abort_add_cin", add_cin, 0);
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;
        start_op(16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        wait_idle();

        // Invalid digit still completes; err cleared by next valid start.
        start_op(16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1, 1'b1);
        wait_idle();
        check("err_held", err, 1);
        start_op(16'h0500, 16'h0499, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b1);
        wait_idle();

        repeat (3) @(negedge Clock);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
